// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg : shared types for the hazard controller |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic pc_write;
    logic fd_write;
    logic de_write;
    logic xm_write;
    logic mw_write;
    logic fd_flush;
    logic de_flush;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input logic pc, input logic fd, input logic de,
                                    input logic xm, input logic mw,
                                    input logic fdf, input logic def);
    ctrl_t c;
    c.pc_write = pc;
    c.fd_write = fd;
    c.de_write = de;
    c.xm_write = xm;
    c.mw_write = mw;
    c.fd_flush = fdf;
    c.de_flush = def;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// +------------------------------------------------------------------+
// | load_use_detect : combinational LW-in-DE vs FD-source compare     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       mem_read_de,
  input  logic [3:0] dst_reg_de,
  input  logic [3:0] rs_fd,
  input  logic [3:0] rt_fd,
  input  logic       uses_rs_fd,
  input  logic       uses_rt_fd,
  output logic       lu
);

  // R0 reads always return zero, so a load targeting it cannot create a hazard.
  assign lu = mem_read_de && (dst_reg_de != REG_ZERO) &&
              ((uses_rs_fd && (rs_fd == dst_reg_de)) ||
               (uses_rt_fd && (rt_fd == dst_reg_de)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush/halt control for the 5-stage   |
// | core. Optional perf counters enabled by macro PERF_CNT_EN.        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_de,
  input  logic [3:0]       dst_reg_de,
  input  logic [3:0]       rs_fd,
  input  logic [3:0]       rt_fd,
  input  logic             uses_rs_fd,
  input  logic             uses_rt_fd,
  input  logic             branch_taken_x,
  input  logic             halt_fd,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             fd_write,
  output logic             de_write,
  output logic             xm_write,
  output logic             mw_write,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int CW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ctrl_t           ctrl;
  logic            halted_c;
  logic            branch_flush;
  logic            lu;

  load_use_detect u_lu (
    .mem_read_de (mem_read_de),
    .dst_reg_de  (dst_reg_de),
    .rs_fd       (rs_fd),
    .rt_fd       (rt_fd),
    .uses_rs_fd  (uses_rs_fd),
    .uses_rt_fd  (uses_rt_fd),
    .lu          (lu)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl         = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    halted_c     = 1'b0;
    branch_flush = 1'b0;
    if (!rst_n) begin
      ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          end else if (branch_taken_x) begin
            ctrl         = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            branch_flush = 1'b1;
          end else if (lu) begin
            ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
          end else if (halt_fd) begin
            ctrl    = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            state_d = ST_DRAIN;
            cnt_d   = CW'(HALT_DRAIN - 1);
          end else begin
            ctrl = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
          end
        end
        ST_DRAIN: begin
          if (mem_busy) begin
            ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          end else if (branch_taken_x) begin
            // HLT sat on the wrong path: resume fetching from the branch target.
            ctrl         = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            branch_flush = 1'b1;
            state_d      = ST_RUN;
          end else begin
            ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            if (cnt_q == '0) begin
              state_d = ST_HALTED;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_HALTED: begin
          halted_c = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write = ctrl.pc_write;
  assign fd_write = ctrl.fd_write;
  assign de_write = ctrl.de_write;
  assign xm_write = ctrl.xm_write;
  assign mw_write = ctrl.mw_write;
  assign fd_flush = ctrl.fd_flush;
  assign de_flush = ctrl.de_flush;
  assign halted   = halted_c;

`ifdef PERF_CNT_EN
  logic             stall_inc;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  assign stall_inc = !ctrl.pc_write && (state_q != ST_HALTED);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_inc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (branch_flush && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  logic unused_perf;
  assign unused_perf  = branch_flush;
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : directed, model-checked bench           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int HALT_DRAIN = 3;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mem_read_de = 1'b0;
  logic [3:0]       dst_reg_de = 4'd0;
  logic [3:0]       rs_fd = 4'd0;
  logic [3:0]       rt_fd = 4'd0;
  logic             uses_rs_fd = 1'b0;
  logic             uses_rt_fd = 1'b0;
  logic             branch_taken_x = 1'b0;
  logic             halt_fd = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_write, fd_write, de_write, xm_write, mw_write;
  logic             fd_flush, de_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_de(mem_read_de), .dst_reg_de(dst_reg_de),
    .rs_fd(rs_fd), .rt_fd(rt_fd), .uses_rs_fd(uses_rs_fd), .uses_rt_fd(uses_rt_fd),
    .branch_taken_x(branch_taken_x), .halt_fd(halt_fd), .mem_busy(mem_busy),
    .pc_write(pc_write), .fd_write(fd_write), .de_write(de_write), .xm_write(xm_write),
    .mw_write(mw_write), .fd_flush(fd_flush), .de_flush(de_flush), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-core view (draining / halted flags, remaining drain cycles).
  bit model_valid = 1'b0;
  bit m_draining  = 1'b0;
  bit m_halted    = 1'b0;
  int m_left      = 0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  always @(negedge clk) begin
    bit       hazard;
    bit [7:0] e;  // {pc, fd, de, xm, mw, fd_flush, de_flush, halted}
    bit       took_branch;
    hazard = mem_read_de && dst_reg_de != 0 &&
             ((uses_rs_fd && rs_fd == dst_reg_de) || (uses_rt_fd && rt_fd == dst_reg_de));
    took_branch = 1'b0;
    if (!rst_n)                 e = 8'b00000_11_0;
    else if (m_halted)          e = 8'b00000_00_1;
    else if (mem_busy)          e = 8'b00000_00_0;
    else if (branch_taken_x)    begin e = 8'b11111_11_0; took_branch = 1'b1; end
    else if (m_draining)        e = 8'b01111_10_0;
    else if (hazard)            e = 8'b00111_01_0;
    else if (halt_fd)           e = 8'b01111_10_0;
    else                        e = 8'b11111_00_0;

    if (model_valid || !rst_n) begin
      chk("ctrl_vec", {24'd0, pc_write, fd_write, de_write, xm_write, mw_write,
                       fd_flush, de_flush, halted}, {24'd0, e});
`ifdef PERF_CNT_EN
      chk("stall_cycles", {16'd0, stall_cycles}, 32'(m_stalls));
      chk("flush_events", {16'd0, flush_events}, 32'(m_flushes));
`else
      chk("stall_cycles", {16'd0, stall_cycles}, 32'd0);
      chk("flush_events", {16'd0, flush_events}, 32'd0);
`endif
    end

    if (!rst_n) begin
      model_valid = 1'b1;
      m_draining  = 1'b0;
      m_halted    = 1'b0;
      m_left      = 0;
      m_stalls    = 0;
      m_flushes   = 0;
    end else if (model_valid) begin
      if (!m_halted && !e[7] && m_stalls < CNT_MAX) m_stalls++;
      if (took_branch && m_flushes < CNT_MAX) m_flushes++;
      if (!m_halted && !mem_busy) begin
        if (took_branch) begin
          m_draining = 1'b0;
        end else if (m_draining) begin
          m_left--;
          if (m_left == 0) begin
            m_draining = 1'b0;
            m_halted   = 1'b1;
          end
        end else if (!hazard && halt_fd) begin
          m_draining = 1'b1;
          m_left     = HALT_DRAIN;
        end
      end
    end
  end

  task automatic cyc(input bit mr, input logic [3:0] dst, input logic [3:0] rs,
                     input logic [3:0] rt, input bit urs, input bit urt,
                     input bit br, input bit hlt, input bit busy);
    @(posedge clk); #1;
    mem_read_de = mr; dst_reg_de = dst; rs_fd = rs; rt_fd = rt;
    uses_rs_fd = urs; uses_rt_fd = urt; branch_taken_x = br; halt_fd = hlt; mem_busy = busy;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    idle(); idle();
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_flushes", {30'd0, fd_flush, de_flush}, 32'd3);
    chk("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    idle();
    chk("run_all_write", {27'd0, pc_write, fd_write, de_write, xm_write, mw_write}, 32'h1F);

    // 1: LW R3 in DE, ADD reads rt=R3
    cyc(1, 3, 1, 3, 1, 1, 0, 0, 0);
    chk("lu_bubble", {29'd0, pc_write, fd_write, de_flush}, 32'b001);
    cyc(0, 0, 1, 3, 1, 1, 0, 0, 0);
    chk("lu_after", 32'(pc_write), 32'd1);
    // rs match stalls, unused rs does not
    cyc(1, 5, 5, 2, 1, 1, 0, 0, 0);
    chk("lu_rs", 32'(pc_write), 32'd0);
    cyc(1, 5, 5, 2, 0, 1, 0, 0, 0);
    chk("lu_rs_unused", 32'(pc_write), 32'd1);

    // 2: LW R0 never stalls
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("r0_no_stall", {30'd0, pc_write, de_flush}, 32'b10);

    // 3: branch beats lu and halt
    cyc(1, 3, 3, 3, 1, 1, 1, 1, 0);
    chk("br_prio", {29'd0, pc_write, fd_flush, de_flush}, 32'b111);
    idle();
    chk("br_stays_run", {30'd0, pc_write, halted}, 32'b10);

    // 4: mem_busy during lu for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(1, 7, 7, 0, 1, 0, 0, 0, 1);
      chk("busy_freeze", {25'd0, pc_write, fd_write, de_write, xm_write, mw_write,
                          fd_flush, de_flush}, 32'd0);
    end
    cyc(1, 7, 7, 0, 1, 0, 0, 0, 0);
    chk("busy_then_lu", {30'd0, pc_write, de_flush}, 32'b01);
    idle();
    chk("busy_lu_done", 32'(pc_write), 32'd1);

    // 5: HLT drain, plain
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("hlt_enter", {30'd0, pc_write, fd_flush}, 32'b01);
    for (int i = 0; i < HALT_DRAIN; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("drain_not_halted", 32'(halted), 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("halted_set", {27'd0, halted, pc_write, fd_write, xm_write, mw_write}, 32'b10000);
    idle();
    chk("halted_sticky", 32'(halted), 32'd1);

    // 6a: reset out of HALTED
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_run", {30'd0, pc_write, halted}, 32'b10);

    // 5b: drain stretched by two busy cycles
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("busy_drain_late", 32'(halted), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("busy_drain_halt", 32'(halted), 32'd1);

    // reset mid-drain, then wrong-path HLT cancelled by branch
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("drain_branch", {29'd0, pc_write, fd_flush, de_flush}, 32'b111);
    idle();
    chk("drain_branch_run", {30'd0, pc_write, halted}, 32'b10);

`ifdef PERF_CNT_EN
    chk("flush_count", {16'd0, flush_events}, 32'd1);
    for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("stall_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
`else
    chk("perf_tied", {stall_cycles, flush_events}, 32'd0);
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
